// File: rtl/mac_bus_ctrl.sv
// Mac Plus bus controller: decodes 68000 bus cycles into chip selects
// and terminates them with dtack_n, vpa_n or berr.
module mac_bus_ctrl #(
  parameter int RAM_WAIT = 1,
  parameter int ROM_WAIT = 2,
  parameter int IO_WAIT  = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        rw_n,
  input  logic [2:0]  fc,
  input  logic [23:1] addr,
  input  logic        overlay,
  input  logic        dev_ready,
  output logic        dtack_n,
  output logic        vpa_n,
  output logic        berr,
  output logic        sel_ram,
  output logic        sel_rom,
  output logic        sel_scsi,
  output logic        sel_scc,
  output logic        sel_iwm,
  output logic        sel_via,
  output logic [1:0]  mem_we_n,
  output logic        mem_oe_n
);

  localparam int WDL = $clog2(TIMEOUT + 1);
  localparam int WDW = (WDL < 8) ? 8 : WDL;
  localparam int CW  = 8;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACK,
    S_VPA,
    S_BERR,
    S_END
  } state_t;

  typedef enum logic [2:0] {
    RG_NONE,
    RG_RAM,
    RG_ROM,
    RG_SCSI,
    RG_SCC,
    RG_IWM,
    RG_VIA,
    RG_IACK
  } region_t;

  logic           r_as_n;
  logic           r_uds_n;
  logic           r_lds_n;
  logic           r_rw_n;
  state_t         r_state;
  state_t         w_nxt;
  region_t        r_region;
  region_t        w_region;
  region_t        w_sel_rg;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  w_wait;
  logic [WDW-1:0] r_wd;
  logic           r_dtack_n;
  logic           r_vpa_n;
  logic           r_berr;
  logic           r_sel_ram;
  logic           r_sel_rom;
  logic           r_sel_scsi;
  logic           r_sel_scc;
  logic           r_sel_iwm;
  logic           r_sel_via;
  logic           w_io;
  logic           w_r_io;
  logic           w_r_map;
  logic           w_act;
  logic           w_wr;
  logic           w_unused;

  assign w_unused = ^addr[18:1];

  // First match wins, so this is a priority chain rather than a case.
  always_comb begin
    w_region = RG_NONE;
    if (fc == 3'b111)
      w_region = RG_IACK;
    else if (addr[23:22] == 2'b00)
      w_region = overlay ? RG_ROM : RG_RAM;
    else if (addr[23:21] == 3'b011 && overlay)
      w_region = RG_RAM;
    else if (addr[23:20] == 4'h4)
      w_region = RG_ROM;
    else if (addr[23:19] == 5'b01011)
      w_region = RG_SCSI;
    else if (addr[23:22] == 2'b10)
      w_region = RG_SCC;
    else if (addr[23:20] == 4'hD)
      w_region = RG_IWM;
    else if (addr[23:20] == 4'hE)
      w_region = RG_VIA;
  end

  always_comb begin
    w_wait = '0;
    case (w_region)
      RG_RAM:  w_wait = CW'(RAM_WAIT);
      RG_ROM:  w_wait = CW'(ROM_WAIT);
      RG_SCSI,
      RG_SCC,
      RG_IWM:  w_wait = CW'(IO_WAIT);
      default: w_wait = '0;
    endcase
  end

  assign w_io    = (w_region == RG_SCSI) |
                   (w_region == RG_SCC)  |
                   (w_region == RG_IWM);
  assign w_r_io  = (r_region == RG_SCSI) |
                   (r_region == RG_SCC)  |
                   (r_region == RG_IWM);
  assign w_r_map = (r_region != RG_NONE);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!r_as_n)
          w_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (r_as_n)
          w_nxt = S_END;
        else if (w_region == RG_VIA || w_region == RG_IACK)
          w_nxt = S_VPA;
        else if (w_region != RG_NONE && !w_io && w_wait == '0)
          w_nxt = S_ACK;
        else
          w_nxt = S_WAIT;
      end
      S_WAIT: begin
        // Watchdog outranks a same-clk counter exit.
        if (r_as_n)
          w_nxt = S_END;
        else if (r_wd == WD_LAST)
          w_nxt = S_BERR;
        else if (w_r_map && r_cnt <= CW'(1) && (!w_r_io || dev_ready))
          w_nxt = S_ACK;
      end
      S_ACK,
      S_VPA,
      S_BERR: begin
        if (r_as_n)
          w_nxt = S_END;
      end
      S_END:   w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  assign w_sel_rg = (r_state == S_DECODE) ? w_region : r_region;
  assign w_act    = (w_nxt == S_WAIT) | (w_nxt == S_ACK) |
                    (w_nxt == S_VPA)  | (w_nxt == S_BERR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_as_n  <= 1'b1;
      r_uds_n <= 1'b1;
      r_lds_n <= 1'b1;
      r_rw_n  <= 1'b1;
    end else begin
      r_as_n  <= as_n;
      r_uds_n <= uds_n;
      r_lds_n <= lds_n;
      r_rw_n  <= rw_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_region <= RG_NONE;
      r_cnt    <= '0;
      r_wd     <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_DECODE) begin
        r_region <= w_region;
        r_cnt    <= w_wait;
        r_wd     <= '0;
      end else if (r_state == S_WAIT) begin
        if (r_cnt != '0)
          r_cnt <= r_cnt - CW'(1);
        r_wd <= r_wd + WDW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dtack_n  <= 1'b1;
      r_vpa_n    <= 1'b1;
      r_berr     <= 1'b0;
      r_sel_ram  <= 1'b0;
      r_sel_rom  <= 1'b0;
      r_sel_scsi <= 1'b0;
      r_sel_scc  <= 1'b0;
      r_sel_iwm  <= 1'b0;
      r_sel_via  <= 1'b0;
    end else begin
      r_dtack_n  <= (w_nxt != S_ACK);
      r_vpa_n    <= (w_nxt != S_VPA);
      r_berr     <= (w_nxt == S_BERR);
      r_sel_ram  <= w_act && (w_sel_rg == RG_RAM);
      r_sel_rom  <= w_act && (w_sel_rg == RG_ROM);
      r_sel_scsi <= w_act && (w_sel_rg == RG_SCSI);
      r_sel_scc  <= w_act && (w_sel_rg == RG_SCC);
      r_sel_iwm  <= w_act && (w_sel_rg == RG_IWM);
      r_sel_via  <= w_act && (w_sel_rg == RG_VIA);
    end
  end

  // Late write strobes flow straight through to the RAM enables.
  assign w_wr = r_sel_ram & ~r_rw_n &
                ((r_state == S_WAIT) | (r_state == S_ACK));

  assign mem_we_n = w_wr ? {r_uds_n, r_lds_n} : 2'b11;
  assign mem_oe_n = ~((r_sel_ram | r_sel_rom) & r_rw_n);

  assign dtack_n  = r_dtack_n;
  assign vpa_n    = r_vpa_n;
  assign berr     = r_berr;
  assign sel_ram  = r_sel_ram;
  assign sel_rom  = r_sel_rom;
  assign sel_scsi = r_sel_scsi;
  assign sel_scc  = r_sel_scc;
  assign sel_iwm  = r_sel_iwm;
  assign sel_via  = r_sel_via;

endmodule

// File: tb/tb_mac_bus_ctrl.sv
// Directed bench for mac_bus_ctrl: decode map, wait states,
// vpa/berr termination, write enables, abort and async reset.
module tb_mac_bus_ctrl;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        as_n = 1'b1;
  logic        uds_n = 1'b1;
  logic        lds_n = 1'b1;
  logic        rw_n = 1'b1;
  logic [2:0]  fc = 3'b101;
  logic [23:1] addr = '0;
  logic        overlay = 1'b0;
  logic        dev_ready = 1'b0;
  logic        dtack_n;
  logic        vpa_n;
  logic        berr;
  logic        sel_ram;
  logic        sel_rom;
  logic        sel_scsi;
  logic        sel_scc;
  logic        sel_iwm;
  logic        sel_via;
  logic [1:0]  mem_we_n;
  logic        mem_oe_n;
  logic [5:0]  sels;
  logic [2:0]  term;

  int n_cmp = 0;
  int n_bad = 0;

  mac_bus_ctrl dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .as_n      (as_n),
    .uds_n     (uds_n),
    .lds_n     (lds_n),
    .rw_n      (rw_n),
    .fc        (fc),
    .addr      (addr),
    .overlay   (overlay),
    .dev_ready (dev_ready),
    .dtack_n   (dtack_n),
    .vpa_n     (vpa_n),
    .berr      (berr),
    .sel_ram   (sel_ram),
    .sel_rom   (sel_rom),
    .sel_scsi  (sel_scsi),
    .sel_scc   (sel_scc),
    .sel_iwm   (sel_iwm),
    .sel_via   (sel_via),
    .mem_we_n  (mem_we_n),
    .mem_oe_n  (mem_oe_n)
  );

  assign sels = {sel_ram, sel_rom, sel_scsi, sel_scc, sel_iwm, sel_via};
  assign term = {dtack_n, vpa_n, berr};

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start(input logic [23:0] ba, input logic rw,
                       input logic [1:0] ds, input logic [2:0] f);
    addr = ba[23:1];
    rw_n = rw;
    {uds_n, lds_n} = ds;
    fc = f;
    as_n = 1'b0;
  endtask

  task automatic end_cycle();
    as_n = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    rw_n = 1'b1;
    tick(3);
  endtask

  task automatic test_reset();
    tick(2);
    n_cmp++;
    if (term !== 3'b110) begin
      n_bad++;
      $display("FAIL reset_term: got %b want 110", term);
    end
    n_cmp++;
    if (sels !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_sel: got %b want 000000", sels);
    end
    n_cmp++;
    if ({mem_we_n, mem_oe_n} !== 3'b111) begin
      n_bad++;
      $display("FAIL reset_mem: got %b want 111", {mem_we_n, mem_oe_n});
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_ram_read();
    overlay = 1'b0;
    start(24'h001000, 1'b1, 2'b00, 3'b101);
    tick(3);
    n_cmp++;
    if (sels !== 6'b100000) begin
      n_bad++;
      $display("FAIL ram_sel: got %b want 100000", sels);
    end
    n_cmp++;
    if ({mem_oe_n, dtack_n} !== 2'b01) begin
      n_bad++;
      $display("FAIL ram_early: got oe/dtack %b want 01", {mem_oe_n, dtack_n});
    end
    tick(1);
    n_cmp++;
    if (dtack_n !== 1'b0) begin
      n_bad++;
      $display("FAIL ram_dtack: got %b want 0", dtack_n);
    end
    as_n = 1'b1;
    tick(2);
    n_cmp++;
    if ({dtack_n, sels, mem_oe_n} !== 8'b10000001) begin
      n_bad++;
      $display("FAIL ram_release: got %b want 10000001",
               {dtack_n, sels, mem_oe_n});
    end
    tick(1);
  endtask

  task automatic test_overlay();
    overlay = 1'b1;
    start(24'h000000, 1'b1, 2'b00, 3'b101);
    tick(3);
    n_cmp++;
    if ({sels, mem_oe_n} !== 7'b0100000) begin
      n_bad++;
      $display("FAIL ovl_rom_sel: got %b want 0100000", {sels, mem_oe_n});
    end
    tick(1);
    n_cmp++;
    if (dtack_n !== 1'b1) begin
      n_bad++;
      $display("FAIL rom_wait: got %b want 1", dtack_n);
    end
    tick(1);
    n_cmp++;
    if (dtack_n !== 1'b0) begin
      n_bad++;
      $display("FAIL rom_dtack: got %b want 0", dtack_n);
    end
    end_cycle();
    start(24'h600000, 1'b1, 2'b00, 3'b101);
    tick(3);
    n_cmp++;
    if (sels !== 6'b100000) begin
      n_bad++;
      $display("FAIL ovl_mirror: got %b want 100000", sels);
    end
    end_cycle();
    start(24'h400000, 1'b0, 2'b00, 3'b101);
    tick(3);
    n_cmp++;
    if ({sels, mem_we_n} !== 8'b01000011) begin
      n_bad++;
      $display("FAIL rom_wr_sel: got %b want 01000011", {sels, mem_we_n});
    end
    tick(2);
    n_cmp++;
    if ({dtack_n, mem_we_n} !== 3'b011) begin
      n_bad++;
      $display("FAIL rom_wr_ack: got %b want 011", {dtack_n, mem_we_n});
    end
    end_cycle();
    overlay = 1'b0;
  endtask

  task automatic test_vpa();
    start(24'h001000, 1'b1, 2'b00, 3'b111);
    tick(3);
    n_cmp++;
    if ({term, sels} !== 9'b100000000) begin
      n_bad++;
      $display("FAIL iack: got %b want 100000000", {term, sels});
    end
    as_n = 1'b1;
    tick(2);
    n_cmp++;
    if (vpa_n !== 1'b1) begin
      n_bad++;
      $display("FAIL iack_release: got %b want 1", vpa_n);
    end
    tick(1);
    start(24'hEFE1FE, 1'b1, 2'b00, 3'b001);
    tick(3);
    n_cmp++;
    if ({term, sels} !== 9'b100000001) begin
      n_bad++;
      $display("FAIL via: got %b want 100000001", {term, sels});
    end
    end_cycle();
  endtask

  task automatic test_io_wait();
    dev_ready = 1'b0;
    start(24'h9FFFF8, 1'b1, 2'b00, 3'b101);
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      n_cmp++;
      if (dtack_n !== 1'b1) begin
        n_bad++;
        $display("FAIL scc_hold clk%0d: got %b want 1", i, dtack_n);
      end
    end
    n_cmp++;
    if (sels !== 6'b000100) begin
      n_bad++;
      $display("FAIL scc_sel: got %b want 000100", sels);
    end
    dev_ready = 1'b1;
    tick(1);
    n_cmp++;
    if (dtack_n !== 1'b0) begin
      n_bad++;
      $display("FAIL scc_ready: got %b want 0", dtack_n);
    end
    end_cycle();
    start(24'h580000, 1'b1, 2'b00, 3'b101);
    tick(6);
    n_cmp++;
    if ({dtack_n, sels} !== 7'b1001000) begin
      n_bad++;
      $display("FAIL scsi_min: got %b want 1001000", {dtack_n, sels});
    end
    tick(1);
    n_cmp++;
    if (dtack_n !== 1'b0) begin
      n_bad++;
      $display("FAIL scsi_dtack: got %b want 0", dtack_n);
    end
    end_cycle();
    dev_ready = 1'b0;
  endtask

  task automatic test_timeout();
    start(24'hF00000, 1'b1, 2'b00, 3'b101);
    tick(TIMEOUT + 2);
    n_cmp++;
    if (term !== 3'b110) begin
      n_bad++;
      $display("FAIL unmap_pre: got %b want 110", term);
    end
    tick(1);
    n_cmp++;
    if ({term, sels} !== 9'b111000000) begin
      n_bad++;
      $display("FAIL unmap_berr: got %b want 111000000", {term, sels});
    end
    as_n = 1'b1;
    tick(2);
    n_cmp++;
    if (berr !== 1'b0) begin
      n_bad++;
      $display("FAIL berr_release: got %b want 0", berr);
    end
    tick(1);
    start(24'hD00000, 1'b1, 2'b00, 3'b101);
    tick(3);
    n_cmp++;
    if (sels !== 6'b000010) begin
      n_bad++;
      $display("FAIL iwm_sel: got %b want 000010", sels);
    end
    tick(TIMEOUT - 1);
    n_cmp++;
    if (berr !== 1'b0) begin
      n_bad++;
      $display("FAIL iwm_pre: got %b want 0", berr);
    end
    tick(1);
    n_cmp++;
    if (term !== 3'b111) begin
      n_bad++;
      $display("FAIL iwm_berr: got %b want 111", term);
    end
    end_cycle();
  endtask

  task automatic test_byte_write();
    start(24'h002000, 1'b0, 2'b10, 3'b101);
    tick(3);
    n_cmp++;
    if ({mem_we_n, mem_oe_n} !== 3'b101) begin
      n_bad++;
      $display("FAIL byte_we: got %b want 101", {mem_we_n, mem_oe_n});
    end
    end_cycle();
    start(24'h002000, 1'b0, 2'b11, 3'b101);
    tick(3);
    n_cmp++;
    if (mem_we_n !== 2'b11) begin
      n_bad++;
      $display("FAIL late_we_pre: got %b want 11", mem_we_n);
    end
    uds_n = 1'b0;
    lds_n = 1'b0;
    tick(1);
    n_cmp++;
    if ({mem_we_n, dtack_n} !== 3'b000) begin
      n_bad++;
      $display("FAIL late_we: got %b want 000", {mem_we_n, dtack_n});
    end
    end_cycle();
  endtask

  task automatic test_abort();
    dev_ready = 1'b0;
    start(24'h9FFFF8, 1'b1, 2'b00, 3'b101);
    tick(5);
    as_n = 1'b1;
    tick(2);
    n_cmp++;
    if ({term, sels} !== 9'b110000000) begin
      n_bad++;
      $display("FAIL abort: got %b want 110000000", {term, sels});
    end
    tick(1);
  endtask

  task automatic test_reset_mid_wait();
    start(24'hD00000, 1'b1, 2'b00, 3'b101);
    tick(5);
    n_cmp++;
    if (sels !== 6'b000010) begin
      n_bad++;
      $display("FAIL mid_sel: got %b want 000010", sels);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({term, sels, mem_we_n, mem_oe_n} !== 12'b110000000111) begin
      n_bad++;
      $display("FAIL async_rst: got %b want 110000000111",
               {term, sels, mem_we_n, mem_oe_n});
    end
    as_n = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(2);
    start(24'h001000, 1'b1, 2'b00, 3'b101);
    tick(3);
    n_cmp++;
    if (dtack_n !== 1'b1) begin
      n_bad++;
      $display("FAIL post_rst_wait: got %b want 1", dtack_n);
    end
    tick(1);
    n_cmp++;
    if (dtack_n !== 1'b0) begin
      n_bad++;
      $display("FAIL post_rst_dtack: got %b want 0", dtack_n);
    end
    end_cycle();
  endtask

  initial begin
    test_reset();
    test_ram_read();
    test_overlay();
    test_vpa();
    test_io_wait();
    test_timeout();
    test_byte_write();
    test_abort();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_bus_ctrl.md
Name: mac_bus_ctrl

Overview:
- Decodes each 68000-style bus cycle driven by the CPU bus wrapper (as_n, uds_n, lds_n, rw_n, fc, addr) into Mac Plus chip selects.
- Returns the cycle-termination signals (dtack_n, vpa_n, berr) that the wrapper consumes.
- Inserts per-region wait states and extends cycles while a slow peripheral is busy.
- Raises a bus error on a watchdog timeout.

Parameters:
RAM_WAIT, 1, clk cycles from decode to dtack_n low for RAM
ROM_WAIT, 2, clk cycles from decode to dtack_n low for ROM
IO_WAIT, 4, minimum clk cycles from decode to dtack_n low for SCSI/SCC/IWM
TIMEOUT, 255, clk cycles after decode before berr is asserted on a cycle with no termination

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
as_n  in  1  address strobe from CPU wrapper
uds_n  in  1  upper data strobe
lds_n  in  1  lower data strobe
rw_n  in  1  1=read 0=write
fc  in  3  function code
addr  in  23  CPU address bits 23:1
overlay  in  1  boot ROM overlay, from VIA port A
dev_ready  in  1  selected SCSI/SCC/IWM can complete the cycle
dtack_n  out  1  data acknowledge to wrapper
vpa_n  out  1  valid peripheral address (VIA and IACK)
berr  out  1  bus error
sel_ram  out  1  RAM cycle active
sel_rom  out  1  ROM cycle active
sel_scsi  out  1  SCSI cycle active
sel_scc  out  1  SCC cycle active
sel_iwm  out  1  IWM cycle active
sel_via  out  1  VIA cycle active
mem_we_n  out  2  byte write enables {upper,lower}, valid in RAM cycles
mem_oe_n  out  1  memory read enable

Behaviour:
- Reset (async, reset_n=0): all state clears to IDLE. dtack_n=1, vpa_n=1, berr=0, all sel_*=0, mem_we_n=2'b11, mem_oe_n=1, counters=0.
- as_n, uds_n, lds_n, rw_n are registered once (1-cycle sync). A cycle starts on the first clk where the registered as_n is 0 while in IDLE.
- Address decode is evaluated in DECODE. The first match wins, in this order:
  - fc==3'b111: IACK, assert vpa_n only.
  - addr[23:22]==00: RAM if overlay=0, ROM if overlay=1.
  - addr[23:21]==011 and overlay=1: RAM (mirror).
  - addr[23:20]==4h4: ROM.
  - addr[23:19]==01011: SCSI.
  - addr[23:21]==100 or 101: SCC.
  - addr[23:20]==4hD: IWM.
  - addr[23:20]==4hE: VIA.
  - anything else: unmapped.
- States:
  - IDLE: wait for cycle start; go to DECODE.
  - DECODE: latch region into the sel_* outputs and load the wait counter with the region WAIT value. VIA or IACK goes to VPA; unmapped goes to WAIT with no termination; all others go to WAIT.
  - WAIT: decrement the counter each clk. When the counter reaches 0, go to ACK. For IO regions the exit additionally requires dev_ready=1.
  - ACK: dtack_n=0; hold until registered as_n=1, then go to END.
  - VPA: vpa_n=0; hold until registered as_n=1, then go to END. E-clock/VMA alignment is handled by the wrapper.
  - BERR: berr=1; hold until registered as_n=1, then go to END.
  - END: deassert dtack_n, vpa_n, berr and all sel_*; go to IDLE. A new cycle cannot start on the same clk.
- Watchdog: an 8+ bit counter (width = clog2(TIMEOUT+1)) clears in DECODE and increments in WAIT. On reaching TIMEOUT it forces BERR from any WAIT, including IO waits with dev_ready held 0 and unmapped cycles. Timeout takes priority over a same-cycle counter==0 exit.
- mem_oe_n=0 while sel_ram|sel_rom and rw_n=1.
- mem_we_n=~{!uds_n,!lds_n} while sel_ram and rw_n=0, using registered strobes. Writes to ROM never drive mem_we_n.
- Write data strobes may arrive up to 2 clk after as_n. mem_we_n tracks the registered strobes live during WAIT and ACK.
- as_n rising before termination (aborted cycle, e.g. wrapper reset): go directly to END from any state; no dtack_n, vpa_n or berr is emitted.
- A WAIT value of 0 gives dtack_n low the clk after DECODE.
- dtack_n, vpa_n and berr are registered outputs, mutually exclusive, and never asserted while the registered as_n=1.

Test Plan:
- Overlay=0, read at addr 0x001000 (byte address): sel_ram=1, mem_oe_n=0, dtack_n low exactly RAM_WAIT+2 clk after as_n falls; released 2 clk after as_n rises.
- Overlay=1, read at 0x000000: sel_rom=1. Read at 0x600000: sel_ram=1. Write at 0x400000: sel_rom=1, mem_we_n stays 11, dtack_n asserted.
- fc=111 with as_n low: vpa_n=0, dtack_n=1, no sel_*. Access at 0xEFE1FE: sel_via=1, vpa_n=0.
- SCC access with dev_ready held 0 for 10 clk, then 1: dtack_n asserted one clk after dev_ready rises, not before IO_WAIT.
- Access at 0xF00000 (unmapped): berr=1 at TIMEOUT+2 clk after as_n falls, dtack_n stays 1. Same for IWM with dev_ready stuck 0.
- Byte write uds_n=1, lds_n=0 to RAM: mem_we_n=2'b10. Assert reset_n=0 mid-WAIT: all outputs return to reset values immediately (async), then a clean IDLE.
